// File: rtl/alu_wb_stage_if.sv
// ============================================================================
// alu_wb_stage_if : ALU-result input and register-file writeback handshakes
// Revision 1.0
// ============================================================================
`default_nettype none

interface alu_wb_stage_if #(
  parameter int N    = 8,
  parameter int RA_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_data;
  logic [3:0]      in_flags;
  logic [RA_W-1:0] in_rd;
  logic            in_we;
  logic            in_setf;
  logic            wb_valid;
  logic            wb_ready;
  logic [N-1:0]    wb_data;
  logic [RA_W-1:0] wb_rd;

  // master: ALU / register-file side; slave: the writeback stage
  modport master (
    output in_valid, in_data, in_flags, in_rd, in_we, in_setf, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_rd
  );

  modport slave (
    input  in_valid, in_data, in_flags, in_rd, in_we, in_setf, wb_ready,
    output in_ready, wb_valid, wb_data, wb_rd
  );
endinterface

`default_nettype wire

// File: rtl/alu_wb_stage.sv
// ============================================================================
// alu_wb_stage : ALU writeback buffer, condition-code register, branch eval
// Optional: WB_SKID_EN selects a 2-entry skid buffer instead of 1 register.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_wb_stage #(
  parameter int N    = 8,
  parameter int RA_W = 3
) (
  input  wire logic       clk,
  input  wire logic       reset,
  alu_wb_stage_if.slave   bus,
  input  wire logic [2:0] cond,
  output logic [3:0]      ccr,
  output logic            taken
);

  logic [1:0]      count_q, count_d;
  logic [N-1:0]    data0_q, data0_d, data1_q, data1_d;
  logic [RA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [3:0]      ccr_q, ccr_d;

  logic            xfer;
  logic            push;
  logic            pop;
  logic [1:0]      count_after_pop;

`ifdef WB_SKID_EN
  assign bus.in_ready = (count_q < 2'd2);
`else
  assign bus.in_ready = (count_q == 2'd0) || bus.wb_ready;
`endif

  assign xfer = bus.in_valid && bus.in_ready;
  assign push = xfer && bus.in_we;
  assign pop  = bus.wb_valid && bus.wb_ready;

  assign count_after_pop = pop ? (count_q - 2'd1) : count_q;

  // Entry 0 is always the head; it keeps its contents when the buffer drains
  // so wb_data/wb_rd hold the last value while empty.
  always_comb begin
    count_d = count_after_pop;
    data0_d = data0_q;
    rd0_d   = rd0_q;
    data1_d = data1_q;
    rd1_d   = rd1_q;
    ccr_d   = ccr_q;

    if (pop && (count_q == 2'd2)) begin
      data0_d = data1_q;
      rd0_d   = rd1_q;
    end

    if (push) begin
      if (count_after_pop == 2'd0) begin
        data0_d = bus.in_data;
        rd0_d   = bus.in_rd;
      end else begin
        data1_d = bus.in_data;
        rd1_d   = bus.in_rd;
      end
      count_d = count_after_pop + 2'd1;
    end

    if (xfer && bus.in_setf) begin
      ccr_d = bus.in_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      data0_q <= '0;
      rd0_q   <= '0;
      data1_q <= '0;
      rd1_q   <= '0;
      ccr_q   <= 4'b0000;
    end else begin
      count_q <= count_d;
      data0_q <= data0_d;
      rd0_q   <= rd0_d;
      data1_q <= data1_d;
      rd1_q   <= rd1_d;
      ccr_q   <= ccr_d;
    end
  end

  assign bus.wb_valid = (count_q != 2'd0);
  assign bus.wb_data  = data0_q;
  assign bus.wb_rd    = rd0_q;
  assign ccr          = ccr_q;

  // ccr bit order: [3]=V [2]=N [1]=Z [0]=C
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'd0: taken = 1'b1;
      3'd1: taken = ccr_q[1];
      3'd2: taken = !ccr_q[1];
      3'd3: taken = ccr_q[0];
      3'd4: taken = !ccr_q[0];
      3'd5: taken = ccr_q[2];
      3'd6: taken = (ccr_q[2] == ccr_q[3]);
      3'd7: taken = (ccr_q[2] != ccr_q[3]);
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/alu_wb_stage.md
# alu_wb_stage

Writeback stage directly downstream of the 8-bit ALU. It captures each ALU result and its V/N/Z/C flags, holds results bound for the register file in a small in-order buffer with a valid/ready handshake, and maintains the architectural condition-code register (CCR). From the CCR it also evaluates branch conditions for the sequencer.

## Interface
- `n`, 8, data width; matches ALU `out` width.
- `RA_W`, 3, destination register address width.
- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — synchronous, active-high.
- `in_valid` input 1 — ALU result presented this cycle.
- `in_ready` output 1 — stage can accept; transfer when `in_valid && in_ready`.
- `in_data` input n — ALU `out`.
- `in_flags` input 4 — ALU flags, [3]=V [2]=N [1]=Z [0]=C.
- `in_rd` input RA_W — destination register.
- `in_we` input 1 — result must be written back.
- `in_setf` input 1 — result updates the CCR.
- `wb_valid` output 1 — writeback entry available.
- `wb_ready` input 1 — register file consumes; pop when `wb_valid && wb_ready`.
- `wb_data` output n — head entry data.
- `wb_rd` output RA_W — head entry address.
- `ccr` output 4 — current condition codes, same bit order as `in_flags`.
- `cond` input 3 — branch condition select.
- `taken` output 1 — condition true, from registered `ccr`.

## Operation
- Acceptance:
  - On a transfer with `in_setf=1`, `ccr <= in_flags` at that edge.
  - With `in_setf=0`, `ccr` holds its value.
- Writeback buffer:
  - A transfer with `in_we=1` pushes {`in_data`, `in_rd`}.
  - A transfer with `in_we=0` pushes nothing but still requires `in_ready`, which keeps ordering.
- The buffer is strictly FIFO; `wb_data`/`wb_rd` always show the head entry and are stable while `wb_valid && !wb_ready`.
- Buffer state is an occupancy count of 0..2 (1 max without skid; see Configuration).
  - Count 0: `wb_valid=0`, and `wb_data`/`wb_rd` hold the last value.
  - Full: `in_ready=0`; `in_valid` is ignored and `ccr` is not updated.
- Simultaneous push and pop with count 1: count stays 1 and the new entry becomes the head on the next cycle.
- Simultaneous push and pop with count 2: cannot occur, because `in_ready=0`.
- Pop with count 0: ignored.
- `taken` is combinational from `ccr` and `cond`:
  - 0 always
  - 1 EQ (Z)
  - 2 NE (!Z)
  - 3 CS (C)
  - 4 CC (!C)
  - 5 MI (N)
  - 6 GE (N==V)
  - 7 LT (N!=V)

## Timing
- Reset values: `ccr=4'b0000`, count=0, `wb_valid=0`, `wb_data=0`, `wb_rd=0`, `in_ready=1`. With `cond=0`, `taken=1`.
- Reset asserted mid-operation drops all buffered entries at that edge; `in_valid` and `wb_ready` are ignored while `reset=1`.
- Latency: a transfer at edge k makes the entry visible with `wb_valid=1` after edge k. The CCR is updated at edge k, so `taken` reflects it in cycle k+1.
- `in_ready` is registered-state-derived only; it has no combinational path from `in_valid`.
- Throughput is one result per cycle while `wb_ready=1`.

## Configuration
- `WB_SKID_EN` defined:
  - 2-entry buffer; `in_ready = (count < 2)`.
  - No combinational `wb_ready`→`in_ready` path.
- `WB_SKID_EN` undefined:
  - Single output register; `in_ready = !wb_valid || wb_ready`. This is a combinational path, and a push and pop in the same cycle replaces the register contents.
  - All other behaviour is identical, including the CCR-only rule that `in_we=0` transfers still wait for `in_ready`.

## Test plan
- Reset, then `in_valid=1` with data 8'h2A, rd 3, `in_we=1`, `in_setf=1`, flags 4'b0000, and `wb_ready=1`:
  - After one edge, expect `wb_valid=1`, `wb_data=8'h2A`, `wb_rd=3`, `ccr=0`.
  - With `cond=1`, expect `taken=0`.
- Back-pressure (skid enabled): hold `wb_ready=0` and offer 3 results, 8'h01, 8'h02, 8'h03.
  - Expect `in_ready=0` after 2 accepts.
  - When `wb_ready` is released, pops come out in order 01, 02; then 03 is accepted and popped.
- Flags only: transfer with `in_we=0`, `in_setf=1`, flags 4'b0010.
  - Expect `wb_valid` unchanged and `ccr=4'b0010`.
  - With `cond=1`, expect `taken=1`; with `cond=2`, expect `taken=0`.
- Condition sweep: load `ccr=4'b1000` (V only).
  - `cond=6` gives `taken=0`; `cond=7` gives `taken=1`.
  - Load `ccr=4'b1100`; `cond=6` gives `taken=1`.
- `in_setf=0` transfer with flags 4'b1111 after `ccr=4'b0001`: expect `ccr` remains 4'b0001.
- Reset mid-operation with 2 entries buffered: after the reset edge, expect `wb_valid=0`, `in_ready=1`, `ccr=0`, and no pop occurs even with `wb_ready=1`.
